// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM states, march element indices and per-element control tables.
package ram_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    localparam int NUM_ELEMS  = 6;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_OPS    = NUM_ELEMS * 2**ADDR_W_DEF;

    // Bit e of each table describes element Me.
    localparam logic [5:0] ELEM_DOWN    = 6'b111000;
    localparam logic [5:0] ELEM_RD      = 6'b111110;
    localparam logic [5:0] ELEM_WR      = 6'b011111;
    localparam logic [5:0] ELEM_EXP_INV = 6'b010100;
    localparam logic [5:0] ELEM_WR_INV  = 6'b001010;

    function automatic int num_ops(input int addr_w);
        return NUM_ELEMS * 2**addr_w;
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: up/down address counter, loadable to 0 or max, with last-address flag.
module ram_bist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              load_max_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (clr_i)
            addr_d = '0;
        else if (load_i)
            addr_d = load_max_i ? '1 : '0;
        else if (step_i)
            addr_d = down_i ? addr_q - 1'b1 : addr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_q <= '0;
        else
            addr_q <= addr_d;
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march BIST initiator (M0..M5) for a single-port RAM with async read.
// Define BIST_FAIL_LOG_EN to build the first-mismatch capture registers (fail_addr/data/elem).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem
);

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              ok_q, ok_d;
    logic [ADDR_W-1:0] addr;
    logic              last, clr, load, load_max, step;
    logic              accept, mismatch;
    logic [2:0]        nxt_elem;
    logic [DATA_W-1:0] exp_pat, wr_pat;

    assign nxt_elem = elem_q + 3'd1;
    assign exp_pat  = ELEM_EXP_INV[elem_q] ? ~BG : BG;
    assign wr_pat   = ELEM_WR_INV[elem_q] ? ~BG : BG;
    assign accept   = start && state_q != RUN;
    assign mismatch = state_q == RUN && ELEM_RD[elem_q] && ram_dout != exp_pat;

    ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .load_i    (load),
        .load_max_i(load_max),
        .step_i    (step),
        .down_i    (ELEM_DOWN[elem_q]),
        .addr_o    (addr),
        .last_o    (last)
    );

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        ok_d     = ok_q;
        clr      = state_q != RUN;
        load     = 1'b0;
        load_max = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                elem_d = M0;
                if (start) begin
                    state_d = RUN;
                    ok_d    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (mismatch)
                    ok_d = 1'b0;
                // Each element starts at its own first address, so the next
                // element's direction decides what the counter reloads to.
                if (last) begin
                    if (elem_q == M5) begin
                        state_d = DONE;
                    end else begin
                        elem_d   = nxt_elem;
                        load     = 1'b1;
                        load_max = ELEM_DOWN[nxt_elem];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            elem_q  <= M0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            ok_q    <= ok_d;
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign pass     = done && ok_q;
    assign ram_we   = busy && ELEM_WR[elem_q];
    assign ram_addr = busy ? addr : '0;
    assign ram_din  = busy ? wr_pat : '0;

`ifdef BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;
    logic [2:0]        fail_elem_q;

    // ok_q still high means this is the first mismatch of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
        end else if (accept) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
        end else if (mismatch && ok_q) begin
            fail_addr_q <= addr;
            fail_data_q <= ram_dout;
            fail_elem_q <= elem_q;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
    assign fail_elem = '0;
`endif

endmodule
